// File: rtl/pulse_rx.sv
// Purpose: receive a stretched pulse from another domain, measure its high width, flag widths out of range.
// Latency: strobe SYNC_STAGES+1 edges after pin is first sampled high; done/err_short the same after first low sample.
// Backpressure: none; events are single-cycle strobes and width holds until the next completed measurement.
module pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 2,
    parameter int MAX_WIDTH   = 16,
    parameter int CNT_W       = $clog2(MAX_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pin,
    output logic             strobe,
    output logic             done,
    output logic [CNT_W-1:0] width,
    output logic             err_short,
    output logic             err_long,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LONG = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic               s;
    logic               s_d;
    logic               rise;
    logic               fall;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   width_nxt;
    logic               strobe_nxt;
    logic               done_nxt;
    logic               err_short_nxt;
    logic               err_long_nxt;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
    assign busy = (state != IDLE);

    // Synchronizer chain and edge-detect delay; a reset chain forces a fresh 0->1 before any rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            s_d  <= s;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            width     <= '0;
            strobe    <= 1'b0;
            done      <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            width     <= width_nxt;
            strobe    <= strobe_nxt;
            done      <= done_nxt;
            err_short <= err_short_nxt;
            err_long  <= err_long_nxt;
        end
    end

    // Next-state logic: disable aborts silently; the counter saturates at MAX_WIDTH by moving to LONG.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        width_nxt     = width;
        strobe_nxt    = 1'b0;
        done_nxt      = 1'b0;
        err_short_nxt = 1'b0;
        err_long_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (ena && rise) begin
                    state_nxt  = HIGH;
                    cnt_nxt    = ONE_C;
                    strobe_nxt = 1'b1;
                end
            end
            HIGH: begin
                if (!ena) begin
                    state_nxt = IDLE;
                end else if (fall) begin
                    state_nxt = IDLE;
                    width_nxt = cnt;
                    if (cnt >= MIN_C) begin
                        done_nxt = 1'b1;
                    end else begin
                        err_short_nxt = 1'b1;
                    end
                end else if (s) begin
                    if (cnt == MAX_C) begin
                        state_nxt    = LONG;
                        err_long_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + ONE_C;
                    end
                end
            end
            LONG: begin
                if (!ena || fall) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
